// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per clock,
// with sign fix-up in a final cycle and a single-cycle write-back pulse.
module mdu_iterative #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  input  logic [4:0]   rd_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [4:0]   rd_out,
  output logic         wb_enable
);

  localparam int unsigned CW = $clog2(N) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic [4:0]     rd_out_q, rd_out_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic           neg_qp_q, neg_qp_d;
  logic           neg_r_q, neg_r_d;
  logic [N-1:0]   result_q, result_d;

  logic           is_div, a_signed, b_signed, sign_a, sign_b;
  logic [N-1:0]   mag_a, mag_b;
  logic           div_zero, div_ovf, accept;
  logic [N:0]     mul_sum, div_shift;
  logic [N-1:0]   div_diff;
  logic           div_ge;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
  assign sign_a   = a_signed & rs1_data[N-1];
  assign sign_b   = b_signed & rs2_data[N-1];
  assign mag_a    = sign_a ? (~rs1_data + 1'b1) : rs1_data;
  assign mag_b    = sign_b ? (~rs2_data + 1'b1) : rs2_data;
  assign div_zero = is_div && (rs2_data == '0);
  assign div_ovf  = is_div && !funct3[0] && (rs1_data == {1'b1, {(N-1){1'b0}}}) &&
                    (rs2_data == '1);
  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));

  // Multiply: acc = {partial high, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[N-1:0] - opnd_q;

  assign prod = neg_qp_q ? (~acc_q + 1'b1) : acc_q;
  assign quo  = neg_qp_q ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
  assign rem  = neg_r_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_qp_d = neg_qp_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;

    case (state_q)
      StCalc: begin
        if (op_q[2]) begin
          acc_d = {(div_ge ? div_diff : div_shift[N-1:0]), acc_q[N-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[N-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        unique case (op_q)
          3'b000:                 result_d = prod[N-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod[2*N-1:N];
          3'b100, 3'b101:         result_d = quo;
          default:                result_d = rem;
        endcase
        rd_out_d = rd_q;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: ;
    endcase

    // Accept overrides the DONE->IDLE default so a held start runs back-to-back.
    if (accept) begin
      op_d     = funct3;
      rd_d     = rd_in;
      neg_qp_d = sign_a ^ sign_b;
      neg_r_d  = sign_a;
      count_d  = '0;
      if (div_zero || div_ovf) begin
        if (div_zero) begin
          result_d = funct3[1] ? rs1_data : '1;
        end else begin
          result_d = funct3[1] ? '0 : {1'b1, {(N-1){1'b0}}};
        end
        rd_out_d = rd_in;
        state_d  = StDone;
      end else begin
        opnd_d  = is_div ? mag_b : mag_a;
        acc_d   = {{N{1'b0}}, (is_div ? mag_a : mag_b)};
        state_d = StCalc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_qp_q <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_qp_q <= neg_qp_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == StCalc) || (state_q == StFix);
  assign done      = (state_q == StDone);
  assign wb_enable = done;
  assign result    = result_q;
  assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table through a scoreboard queue,
// plus hand sequences for reset abort, ignored start and back-to-back issue.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_enable;
  logic [31:0] result;
  logic [4:0]  rd_out;

  mdu_iterative #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .wb_enable (wb_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  vec_t vecs[22];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Latency is counted in edges after the accept edge, sampled on the falling edge.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with rd_out %0d result %h, want no done",
                 rd_out, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", 32'(rd_out), 32'(e.rd));
        check("wb_enable", 32'(wb_enable), 32'd1);
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    funct3   = op;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    e = '{res: exp, rd: rd, acc: cyc + 1, lat: lat};
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
    check("busy_after_accept", 32'(busy), (lat != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int d0;
    int n;
    exp_t e;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'b000, 32'd0,        32'd12345,    32'd0,        33};
    vecs[9]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        33};
    vecs[10] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[12] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
    vecs[13] = '{3'b011, 32'h12345678, 32'h10,       32'd1,        33};
    vecs[14] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    vecs[15] = '{3'b111, 32'd5,        32'd0,        32'd5,        0};
    vecs[16] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[17] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    vecs[18] = '{3'b100, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF, 0};
    vecs[19] = '{3'b110, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 0};
    vecs[20] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[21] = '{3'b111, 32'hFFFFFFFF, 32'h10,       32'hF,        33};

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wb_enable", 32'(wb_enable), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat);
      wait_idle();
    end

    // Start pulses during CALC must be dropped.
    d0 = done_cnt;
    issue(3'b000, 32'd7, 32'd3, 5'd4, 32'd21, 33);
    repeat (3) @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd9; rs2_data = 32'd3; rd_in = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);

    // Held start: second op accepted on the DONE edge.
    @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd5; start = 1'b1;
    e = '{res: 32'd14, rd: 5'd5, acc: cyc + 1, lat: 33};
    sb.push_back(e);
    @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd4; rd_in = 5'd9;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!done && n < 50);
    check("b2b_first_done_seen", 32'(done), 32'd1);
    e = '{res: 32'd12, rd: 5'd9, acc: cyc + 1, lat: 33};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("b2b_busy_after_done", 32'(busy), 32'd1);
    check("b2b_rd_out_held", 32'(rd_out), 32'd5);
    check("b2b_result_held", result, 32'd14);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-operation aborts without a done.
    @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd7; rs2_data = 32'd3; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", 32'(rd_out), 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
